// File: rtl/seg_reader.sv
// seg_reader: passive monitor for a seven-segment digit display.
// Synchronizes and de-glitches the segment bus, decodes each newly stable
// pattern back to a BCD digit, and checks that successive digits step by
// exactly +1 or -1 (mod 10). Reports the inferred count direction, a
// saturating count of accepted digits, and strobes for bad steps and for
// patterns that are neither a digit nor blank. It never drives the bus.
module seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4   // legal range 2..15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] display,
    output logic [3:0] number,
    output logic       valid,
    output logic       digit_ok,
    output logic       dir,
    output logic       step_err,
    output logic       seg_err,
    output logic [7:0] steps
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,   // no reference digit; next digit is not step-checked
        ST_TRACK = 1'b1    // prev_q holds the last accepted digit
    } state_t;

    localparam logic [3:0] STABLE_W  = 4'(STABLE_CYCLES);
    localparam logic [3:0] ACCEPT_AT = 4'(STABLE_CYCLES - 1);
    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [7:0] STEPS_MAX = 8'hFF;

    // Segment pattern (bits g..a) to {legal, digit}. Blank decodes as
    // not-legal here and is distinguished separately by the caller.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h3F:   r = {1'b1, 4'd0};
            7'h06:   r = {1'b1, 4'd1};
            7'h5B:   r = {1'b1, 4'd2};
            7'h4F:   r = {1'b1, 4'd3};
            7'h66:   r = {1'b1, 4'd4};
            7'h6D:   r = {1'b1, 4'd5};
            7'h7D:   r = {1'b1, 4'd6};
            7'h07:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h6F:   r = {1'b1, 4'd9};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Input path
    logic [6:0] s1_q, s2_q;
    logic [6:0] h_q, h_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] last_acc_q, last_acc_d;
    logic       accept;

    // Tracking FSM and registered outputs
    state_t     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] number_q, number_d;
    logic       valid_q, valid_d;
    logic       digit_ok_q, digit_ok_d;
    logic       dir_q, dir_d;
    logic       step_err_q, step_err_d;
    logic       seg_err_q, seg_err_d;
    logic [7:0] steps_q, steps_d;

    // Decode of the held pattern
    logic       dec_legal;
    logic [3:0] dec_digit;
    logic       dec_blank;
    logic [3:0] delta;

    // ------------------------------------------------------------------
    // Glitch filter: restart the dwell count on any change, otherwise
    // count up to STABLE_CYCLES. Acceptance fires on the edge the count
    // reaches STABLE_CYCLES, and only for a pattern differing from the
    // last one accepted, so a glitch that returns to the same pattern
    // produces no new event. A change on that edge wins: the old pattern
    // is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        h_d        = h_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        last_acc_d = last_acc_q;

        if (s2_q != h_q) begin
            h_d   = s2_q;
            cnt_d = 4'd1;
        end else if (cnt_q < STABLE_W) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q == ACCEPT_AT) && (h_q != last_acc_q)) begin
                accept     = 1'b1;
                last_acc_d = h_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode the held pattern and compute (digit - prev) mod 10.
    // ------------------------------------------------------------------
    always_comb begin
        {dec_legal, dec_digit} = seg_decode(h_q);
        dec_blank              = (h_q == PAT_BLANK);
        // Both operands are 0..9; the 4-bit wrap in the second branch
        // cancels out because the true result is always below 16.
        if (dec_digit >= prev_q) begin
            delta = dec_digit - prev_q;
        end else begin
            delta = dec_digit + 4'd10 - prev_q;
        end
    end

    // ------------------------------------------------------------------
    // Tracking FSM: classify each accepted pattern, check the step against
    // the previous digit when one is held, and form next output values.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        number_d   = number_q;
        digit_ok_d = digit_ok_q;
        dir_d      = dir_q;
        steps_d    = steps_q;
        valid_d    = 1'b0;
        step_err_d = 1'b0;
        seg_err_d  = 1'b0;

        if (accept) begin
            if (dec_legal) begin
                number_d   = dec_digit;
                prev_d     = dec_digit;
                valid_d    = 1'b1;
                digit_ok_d = 1'b1;
                state_d    = ST_TRACK;
                if (steps_q != STEPS_MAX) begin
                    steps_d = steps_q + 8'd1;
                end
                // The first digit after EMPTY only establishes a reference.
                if (state_q == ST_TRACK) begin
                    if (delta == 4'd1) begin
                        dir_d = 1'b0;
                    end else if (delta == 4'd9) begin
                        dir_d = 1'b1;
                    end else begin
                        step_err_d = 1'b1;
                    end
                end
            end else if (dec_blank) begin
                digit_ok_d = 1'b0;
                state_d    = ST_EMPTY;
            end else begin
                seg_err_d  = 1'b1;
                digit_ok_d = 1'b0;
                state_d    = ST_EMPTY;
            end
        end
    end

    // ------------------------------------------------------------------
    // All state: synchronizer, filter, FSM and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q       <= 7'h00;
            s2_q       <= 7'h00;
            h_q        <= 7'h00;
            cnt_q      <= 4'd0;
            last_acc_q <= 7'h00;
            state_q    <= ST_EMPTY;
            prev_q     <= 4'd0;
            number_q   <= 4'd0;
            valid_q    <= 1'b0;
            digit_ok_q <= 1'b0;
            dir_q      <= 1'b0;
            step_err_q <= 1'b0;
            seg_err_q  <= 1'b0;
            steps_q    <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its source; blocking would collapse s1/s2
            // into a single stage.
            s1_q       <= display;
            s2_q       <= s1_q;
            h_q        <= h_d;
            cnt_q      <= cnt_d;
            last_acc_q <= last_acc_d;
            state_q    <= state_d;
            prev_q     <= prev_d;
            number_q   <= number_d;
            valid_q    <= valid_d;
            digit_ok_q <= digit_ok_d;
            dir_q      <= dir_d;
            step_err_q <= step_err_d;
            seg_err_q  <= seg_err_d;
            steps_q    <= steps_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign number   = number_q;
    assign valid    = valid_q;
    assign digit_ok = digit_ok_q;
    assign dir      = dir_q;
    assign step_err = step_err_q;
    assign seg_err  = seg_err_q;
    assign steps    = steps_q;

endmodule

// File: doc/seg_reader.md
# seg_reader

Seven-segment reader and monitor: the receiving end of the digit display driven by the counter circuit. It samples the 7-bit segment bus, filters glitches, decodes the stable pattern back to a BCD digit and checks that successive digits step by exactly ±1 (mod 10). It reports the inferred count direction and flags illegal patterns and illegal steps. It sits on the display bus in self-check builds and on a bench, and never drives the bus.

## Interface
- STABLE_CYCLES, default 4: consecutive identical synchronized samples required before a pattern is accepted; legal range 2..15.
- clock  in  1  rising-edge clock, same clock as the display driver.
- reset  in  1  asynchronous, active-high; clears all state.
- display  in  7  segment bus, bit0 = a … bit6 = g, 1 = segment lit.
- number  out  4  last accepted valid digit, 0..9.
- valid  out  1  one-cycle strobe: number updated with a newly accepted digit.
- digit_ok  out  1  level: the last accepted pattern was a legal digit.
- dir  out  1  0 = counting up, 1 = counting down; updated only on a legal step.
- step_err  out  1  one-cycle strobe: an accepted digit is not ±1 from the previous one.
- seg_err  out  1  one-cycle strobe: an accepted pattern is neither a digit nor blank.
- steps  out  8  count of accepted valid digits; saturates at 255.

## Operation
- Legal patterns, as bits g..a: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Blank = 0x00.
- Input path: two-flop synchronizer s1→s2, then a hold register h and a 4-bit counter cnt.
- Each edge:
  - if s2 ≠ h: h ← s2, cnt ← 1;
  - else if cnt < STABLE_CYCLES: cnt increments.
- Acceptance event: on the edge where cnt goes from STABLE_CYCLES−1 to STABLE_CYCLES, and only if h ≠ last_acc.
  - On acceptance, last_acc ← h.
  - A pattern that glitches away and returns to last_acc does not produce a new event.
- FSM states: EMPTY (no reference digit) and TRACK (prev digit held).
- On an acceptance event:
  - Legal digit d, state EMPTY: number ← d, valid, digit_ok ← 1, steps++, go to TRACK. No step check is made.
  - Legal digit d, state TRACK: delta = (d − prev) mod 10.
    - delta 1: dir ← 0.
    - delta 9: dir ← 1.
    - Any other delta: step_err pulses and dir is held.
    - In every case: number ← d, valid, steps++, prev ← d, stay in TRACK.
  - Blank: digit_ok ← 0, go to EMPTY. No strobe; number is held.
  - Illegal pattern: seg_err pulses, digit_ok ← 0, go to EMPTY; number is held.
- steps holds at 255 once saturated. It is cleared only by reset.

## Timing
- Reset (asynchronous) clears s1, s2, h, last_acc and prev to 0x00. cnt=0, FSM=EMPTY.
- Reset values of all outputs: number=0, valid=0, digit_ok=0, dir=0, step_err=0, seg_err=0, steps=0.
- Outputs are registered.
- Latency: a new pattern first sampled at edge 1 and held steady raises valid/seg_err after edge STABLE_CYCLES+2. That is after edge 6 with the default.
- valid, step_err and seg_err last exactly one cycle. step_err is only ever coincident with valid.
- A pattern that changes before stabilising restarts cnt at 1 and produces no event.
- A change landing on the acceptance edge: the old h is not accepted.
- Reset asserted mid-stability or mid-TRACK aborts immediately. The first digit accepted after release is treated as EMPTY (no step check).
- Minimum pattern dwell for detection: STABLE_CYCLES cycles.

## Test plan
- Reset, then drive 0x3F steady for 10 cycles -> valid after edge 6, number=0, digit_ok=1, steps=1, step_err=0.
- Sequence 0x3F→0x06→0x5B, each held 8 cycles -> numbers 0,1,2, dir=0, steps=3. Then 0x5B→0x06 -> dir=1, no step_err.
- Wrap: 9 (0x6F)→0 (0x3F) -> dir=0, no error. Then 0→9 -> dir=1, no error. Then 9→5 (0x6D) -> step_err pulse with valid, number=5, dir stays 1.
- Glitches: after 3, drive 0x7F for 3 cycles, then back to 0x4F -> no valid, no error. Then 0x00 held -> digit_ok=0, no strobe. Then 0x66 -> valid, number=4, no step_err (EMPTY).
- Illegal pattern 0x49 held -> seg_err single pulse, number unchanged, digit_ok=0. The next legal digit gives no step check.
- Drive 256 legal alternating steps -> steps saturates at 255. Assert reset mid-stabilisation -> all outputs 0 immediately.
